// File: rtl/channel_level_ctrl.sv
// channel_level_ctrl: two independent saturating level registers driven by
// up/down requests, with press detection, hold delay and auto-repeat.
// Each channel emits a one-cycle step pulse when its level moves and a
// one-cycle sat pulse when a step is blocked at a bound.
module channel_level_ctrl #(
  parameter int W             = 4,
  parameter int MAX_LEVEL     = 15,
  parameter int INIT_LEVEL    = 0,
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Ch1_up,
  input  logic         Ch1_down,
  input  logic         Ch2_up,
  input  logic         Ch2_down,
  output logic [W-1:0] Ch1_level,
  output logic [W-1:0] Ch2_level,
  output logic         Ch1_step,
  output logic         Ch2_step,
  output logic         Ch1_sat,
  output logic         Ch2_sat
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Bit order of the request vector: {Ch2_down, Ch2_up, Ch1_down, Ch1_up}
  logic [3:0]     r_sync1;
  logic [3:0]     r_sync2;
  logic [2*W-1:0] w_level_all;
  logic [1:0]     w_step_all;
  logic [1:0]     w_sat_all;

  // Two-flop synchronizer for the four asynchronous request inputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= {Ch2_down, Ch2_up, Ch1_down, Ch1_up};
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic           w_req_up;
    logic           w_req_dn;
    logic           w_held;
    state_t         r_state;
    state_t         w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic           r_dir;      // 1'b0 = up, 1'b1 = down
    logic           w_dir_nxt;
    logic           w_do_step;
    logic           w_step_dir;
    logic [W-1:0]   r_level;
    logic [W-1:0]   w_level_nxt;
    logic           r_step;
    logic           w_step_nxt;
    logic           r_sat;
    logic           w_sat_nxt;

    // Conflicting requests (both high) cancel out to no request
    assign w_req_up = r_sync2[2*g]   & ~r_sync2[2*g+1];
    assign w_req_dn = r_sync2[2*g+1] & ~r_sync2[2*g];
    // Request for the latched direction still present
    assign w_held   = r_dir ? w_req_dn : w_req_up;

    // Press / hold / auto-repeat sequencing
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dir_nxt   = r_dir;
      w_do_step   = 1'b0;
      w_step_dir  = r_dir;
      case (r_state)
        ST_IDLE: begin
          if (w_req_up || w_req_dn) begin
            w_do_step   = 1'b1;
            w_step_dir  = w_req_dn;
            w_dir_nxt   = w_req_dn;
            w_cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          if (!w_held) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else if (r_cnt == '0) begin
            w_do_step   = 1'b1;
            w_cnt_nxt   = CNT_W'(REPEAT_CYCLES - 1);
            w_state_nxt = ST_REPEAT;
          end else begin
            w_cnt_nxt   = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    // Saturating step application; a blocked step becomes a sat pulse
    always_comb begin
      w_level_nxt = r_level;
      w_step_nxt  = 1'b0;
      w_sat_nxt   = 1'b0;
      if (w_do_step) begin
        if (!w_step_dir) begin
          if (r_level < W'(MAX_LEVEL)) begin
            w_level_nxt = r_level + W'(1);
            w_step_nxt  = 1'b1;
          end else begin
            w_sat_nxt   = 1'b1;
          end
        end else begin
          if (r_level != '0) begin
            w_level_nxt = r_level - W'(1);
            w_step_nxt  = 1'b1;
          end else begin
            w_sat_nxt   = 1'b1;
          end
        end
      end else begin
        w_level_nxt = r_level;
      end
    end

    // Channel state, level and pulse registers
    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_dir   <= 1'b0;
        r_level <= W'(INIT_LEVEL);
        r_step  <= 1'b0;
        r_sat   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_dir   <= w_dir_nxt;
        r_level <= w_level_nxt;
        r_step  <= w_step_nxt;
        r_sat   <= w_sat_nxt;
      end
    end

    assign w_level_all[g*W +: W] = r_level;
    assign w_step_all[g]         = r_step;
    assign w_sat_all[g]          = r_sat;
  end

  assign Ch1_level = w_level_all[W-1:0];
  assign Ch2_level = w_level_all[2*W-1:W];
  assign Ch1_step  = w_step_all[0];
  assign Ch2_step  = w_step_all[1];
  assign Ch1_sat   = w_sat_all[0];
  assign Ch2_sat   = w_sat_all[1];

endmodule

// File: tb/tb_channel_level_ctrl.sv
// Scoreboard bench for channel_level_ctrl: a press/hold-time reference model
// pushes the expected output word for every clock edge; a monitor pops and
// compares one entry per cycle.
module tb_channel_level_ctrl;

  localparam int W    = 4;
  localparam int MAXL = 15;
  localparam int INIT = 0;
  localparam int H    = 8;
  localparam int R    = 4;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic [3:0]   tb_in = 4'b0000;   // {Ch2_down, Ch2_up, Ch1_down, Ch1_up}
  logic         Ch1_up, Ch1_down, Ch2_up, Ch2_down;
  logic [W-1:0] Ch1_level, Ch2_level;
  logic         Ch1_step, Ch2_step, Ch1_sat, Ch2_sat;

  assign Ch1_up   = tb_in[0];
  assign Ch1_down = tb_in[1];
  assign Ch2_up   = tb_in[2];
  assign Ch2_down = tb_in[3];

  channel_level_ctrl #(
    .W(W), .MAX_LEVEL(MAXL), .INIT_LEVEL(INIT),
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .Ch1_up(Ch1_up), .Ch1_down(Ch1_down), .Ch2_up(Ch2_up), .Ch2_down(Ch2_down),
    .Ch1_level(Ch1_level), .Ch2_level(Ch2_level),
    .Ch1_step(Ch1_step), .Ch2_step(Ch2_step),
    .Ch1_sat(Ch1_sat), .Ch2_sat(Ch2_sat)
  );

  always #5 Clk = ~Clk;

  // expected word: {lvl1, lvl2, step1, step2, sat1, sat2}
  logic [2*W+3:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [2*W+3:0] pack(input int l1, input int l2,
                                          input bit t1, input bit t2,
                                          input bit s1, input bit s2);
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = W'(l1);
    b = W'(l2);
    return {a, b, t1, t2, s1, s2};
  endfunction

  // Reference model: a request becomes a press; while the same direction is
  // requested the n-th held edge after the press steps when n==0 or when
  // n>=H and (n-H) is a multiple of R. Inputs reach the decision 2 edges late.
  initial begin
    int  lvl[2];
    bit  active[2];
    int  dir[2];      // 1 = up, 2 = down
    int  n[2];
    logic [3:0] h1, h2;
    bit  t[2], s[2];
    lvl[0] = INIT; lvl[1] = INIT;
    active[0] = 0; active[1] = 0;
    dir[0] = 0; dir[1] = 0;
    n[0] = 0; n[1] = 0;
    h1 = 4'b0000; h2 = 4'b0000;
    forever begin
      @(posedge Clk);
      if (!Reset) begin
        lvl[0] = INIT; lvl[1] = INIT;
        active[0] = 0; active[1] = 0;
        h1 = 4'b0000; h2 = 4'b0000;
        exp_q.push_back(pack(INIT, INIT, 1'b0, 1'b0, 1'b0, 1'b0));
      end else begin
        for (int c = 0; c < 2; c++) begin
          int  req;
          bit  fire;
          bit  up, dn;
          up = h2[2*c];
          dn = h2[2*c+1];
          req = (up && !dn) ? 1 : ((dn && !up) ? 2 : 0);
          fire = 0;
          t[c] = 0;
          s[c] = 0;
          if (active[c]) begin
            if (req == dir[c]) begin
              n[c]++;
              fire = (n[c] >= H) && (((n[c] - H) % R) == 0);
            end else begin
              active[c] = 0;
            end
          end else if (req != 0) begin
            active[c] = 1;
            dir[c] = req;
            n[c] = 0;
            fire = 1;
          end
          if (fire) begin
            if (dir[c] == 1) begin
              if (lvl[c] < MAXL) begin lvl[c]++; t[c] = 1; end
              else s[c] = 1;
            end else begin
              if (lvl[c] > 0) begin lvl[c]--; t[c] = 1; end
              else s[c] = 1;
            end
          end
        end
        exp_q.push_back(pack(lvl[0], lvl[1], t[0], t[1], s[0], s[1]));
        h2 = h1;
        h1 = tb_in;
      end
    end
  end

  // Monitor: one expected entry per edge, compared 1 time unit after the edge
  initial begin
    logic [2*W+3:0] got;
    logic [2*W+3:0] exp;
    forever begin
      @(posedge Clk);
      #1;
      got = {Ch1_level, Ch2_level, Ch1_step, Ch2_step, Ch1_sat, Ch2_sat};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty t=%0t got=%h required=entry", $time, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_bad++;
          $display("FAIL outputs t=%0t got l1=%0d l2=%0d st=%b%b sat=%b%b required l1=%0d l2=%0d st=%b%b sat=%b%b",
                   $time, got[2*W+3:W+4], got[W+3:4], got[3], got[2], got[1], got[0],
                   exp[2*W+3:W+4], exp[W+3:4], exp[3], exp[2], exp[1], exp[0]);
        end
      end
    end
  end

  task automatic hold(input logic [3:0] v, input int cyc);
    @(negedge Clk);
    tb_in = v;
    repeat (cyc - 1) @(negedge Clk);
  endtask

  task automatic pulse_reset(input int cyc);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (cyc) @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0;
    tb_in = 4'b0000;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    // idle after reset
    hold(4'b0000, 20);
    // single-cycle press on Ch1_up
    hold(4'b0001, 1);
    hold(4'b0000, 10);
    // Ch2_up held 30 cycles: auto-repeat
    hold(4'b0100, 30);
    hold(4'b0000, 10);
    // Ch1 driven to the top, then held at the bound
    hold(4'b0001, 70);
    hold(4'b0000, 5);
    hold(4'b0001, 12);
    hold(4'b0000, 5);
    // Ch1 driven to zero, then held at the bound
    hold(4'b0010, 70);
    hold(4'b0000, 5);
    hold(4'b0010, 12);
    hold(4'b0000, 5);
    // both directions high, then drop down
    hold(4'b0011, 6);
    hold(4'b0001, 1);
    hold(4'b0000, 5);
    // direct reversal up -> down
    hold(4'b0001, 5);
    hold(4'b0010, 5);
    hold(4'b0000, 5);
    // bring both channels to 3/3
    pulse_reset(2);
    for (int i = 0; i < 3; i++) begin
      hold(4'b0101, 1);
      hold(4'b0000, 3);
    end
    // lockstep Ch1 up / Ch2 down, then reset mid-repeat with inputs held
    hold(4'b1001, 20);
    Reset = 1'b0;
    #1;
    n_cmp++;
    if (Ch1_level !== W'(INIT) || Ch2_level !== W'(INIT)) begin
      n_bad++;
      $display("FAIL async_reset got l1=%0d l2=%0d required l1=%0d l2=%0d",
               Ch1_level, Ch2_level, INIT, INIT);
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    hold(4'b1001, 15);
    hold(4'b0000, 5);
    // randomized: sticky toggles give long holds, occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(11, 0) == 0) tb_in[b] = ~tb_in[b];
      end
      if ($urandom_range(399, 0) == 0) begin
        Reset = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
      end
    end
    hold(4'b0000, 10);
    @(posedge Clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
